// File: rtl/gpr_wb_pkg.sv
// Shared constants and helpers for the GPR write-back arbiter.
package gpr_wb_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned NUM_GPR        = 32;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   // Requester ids double as the grant_id / last_grant encoding.
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   function automatic logic [NUM_GPR-1:0] reg_onehot(input reg_addr_t rd, input logic en);
      logic [NUM_GPR-1:0] mask;
      mask = '0;
      if (en) begin
         mask[rd] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of the two write-back request channels and the register file write port.
interface gpr_wb_arbiter_if #(
   parameter int unsigned REG_DATA_WIDTH = 32
);
   import gpr_wb_pkg::*;

   logic                      req0_valid;
   logic                      req0_ready;
   reg_addr_t                 req0_rd;
   logic [REG_DATA_WIDTH-1:0] req0_data;

   logic                      req1_valid;
   logic                      req1_ready;
   reg_addr_t                 req1_rd;
   logic [REG_DATA_WIDTH-1:0] req1_data;

   reg_addr_t                 write_reg;
   logic [REG_DATA_WIDTH-1:0] din;
   logic                      din_enable;
   logic                      grant_id;
   logic [NUM_GPR-1:0]        pending_mask;

   modport master (
      output req0_valid, req0_rd, req0_data,
      output req1_valid, req1_rd, req1_data,
      input  req0_ready, req1_ready,
      input  write_reg, din, din_enable, grant_id, pending_mask
   );

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      input  req1_valid, req1_rd, req1_data,
      output req0_ready, req1_ready,
      output write_reg, din, din_enable, grant_id, pending_mask
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input grant logic with last_grant history.
// GPR_WB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module rr_arbiter2
   import gpr_wb_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic valid0_i,
   input  logic valid1_i,
   output logic grant0_o,
   output logic grant1_o
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      grant0_o = 1'b0;
      grant1_o = 1'b0;
      if (!reset_i) begin
`ifdef GPR_WB_ROUND_ROBIN_EN
         if (valid0_i && valid1_i) begin
            // The requester that did not win last time goes first.
            if (last_grant_q == REQ_ALU) begin
               grant1_o = 1'b1;
            end else begin
               grant0_o = 1'b1;
            end
         end else begin
            grant0_o = valid0_i;
            grant1_o = valid1_i;
         end
`else
         grant0_o = valid0_i;
         grant1_o = valid1_i & ~valid0_i;
`endif
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant0_o) begin
         last_grant_d = REQ_ALU;
      end else if (grant1_o) begin
         last_grant_d = REQ_LSU;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_grant_q <= REQ_LSU;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: one grant per cycle into a registered write port plus pending mask.
// Arbitration policy is chosen by GPR_WB_ROUND_ROBIN_EN (undefined: fixed priority to the ALU).
module gpr_wb_arbiter
   import gpr_wb_pkg::*;
#(
   parameter int unsigned REG_DATA_WIDTH = 32
) (
   input  logic               CLK,
   input  logic               RESET,
   gpr_wb_arbiter_if.slave    bus
);

   logic                      grant0, grant1, accept;
   reg_addr_t                 sel_rd;
   logic [REG_DATA_WIDTH-1:0] sel_data;

   reg_addr_t                 write_reg_q, write_reg_d;
   logic [REG_DATA_WIDTH-1:0] din_q, din_d;
   logic                      din_enable_q, din_enable_d;
   logic                      grant_id_q, grant_id_d;
   logic [NUM_GPR-1:0]        pending;

   rr_arbiter2 u_arb (
      .clk_i    (CLK),
      .reset_i  (RESET),
      .valid0_i (bus.req0_valid),
      .valid1_i (bus.req1_valid),
      .grant0_o (grant0),
      .grant1_o (grant1)
   );

   assign accept   = grant0 | grant1;
   assign sel_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
   assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

   always_comb begin
      write_reg_d  = write_reg_q;
      din_d        = din_q;
      din_enable_d = 1'b0;
      grant_id_d   = grant_id_q;
      if (accept) begin
         write_reg_d  = sel_rd;
         din_d        = sel_data;
         // x0 is hardwired to zero, so the handshake completes without a write strobe.
         din_enable_d = (sel_rd != ZERO_REG);
         grant_id_d   = grant1 ? REQ_LSU : REQ_ALU;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         write_reg_q  <= ZERO_REG;
         din_q        <= '0;
         din_enable_q <= 1'b0;
         grant_id_q   <= REQ_ALU;
      end else begin
         write_reg_q  <= write_reg_d;
         din_q        <= din_d;
         din_enable_q <= din_enable_d;
         grant_id_q   <= grant_id_d;
      end
   end

   always_comb begin
      pending    = reg_onehot(bus.req0_rd, bus.req0_valid)
                 | reg_onehot(bus.req1_rd, bus.req1_valid)
                 | reg_onehot(write_reg_q, din_enable_q);
      pending[0] = 1'b0;
   end

   assign bus.req0_ready   = grant0;
   assign bus.req1_ready   = grant1;
   assign bus.write_reg    = write_reg_q;
   assign bus.din          = din_q;
   assign bus.din_enable   = din_enable_q;
   assign bus.grant_id     = grant_id_q;
   assign bus.pending_mask = pending;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus a randomized model check.
module tb_gpr_wb_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gpr_wb_arbiter_if #(.REG_DATA_WIDTH(32)) bus ();

   gpr_wb_arbiter #(.REG_DATA_WIDTH(32)) dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
      bus.req0_valid = v0; bus.req0_rd = rd0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_rd = rd1; bus.req1_data = d1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd9, 32'hBBBB_0009);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready got %b%b exp 00", bus.req0_ready, bus.req1_ready); end
         checks++; if (bus.din_enable !== 1'b0) begin errors++;
            $display("FAIL reset_din_enable got %b exp 0", bus.din_enable); end
         checks++; if (bus.write_reg !== 5'd0 || bus.din !== 32'd0 || bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got wr=%0d din=%h gid=%b exp 0/0/0",
                               bus.write_reg, bus.din, bus.grant_id); end
         checks++; if (bus.pending_mask !== 32'h0000_0208) begin errors++;
            $display("FAIL reset_pending got %h exp 00000208", bus.pending_mask); end
         tick();
      end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++;
         $display("FAIL post_reset_grant got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b1 || bus.write_reg !== 5'd3 || bus.din !== 32'hAAAA_0003
                    || bus.grant_id !== 1'b0) begin errors++;
         $display("FAIL post_reset_write got en=%b wr=%0d din=%h gid=%b exp 1/3/aaaa0003/0",
                  bus.din_enable, bus.write_reg, bus.din, bus.grant_id); end
      checks++; if (bus.req1_ready !== 1'b1 || bus.pending_mask !== 32'h0000_0208) begin errors++;
         $display("FAIL post_reset_req1 got rdy=%b mask=%h exp 1/00000208",
                  bus.req1_ready, bus.pending_mask); end
      tick();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.write_reg !== 5'd9 || bus.din !== 32'hBBBB_0009 || bus.grant_id !== 1'b1
                    || bus.pending_mask !== 32'h0000_0200) begin errors++;
         $display("FAIL post_reset_write1 got wr=%0d din=%h gid=%b mask=%h",
                  bus.write_reg, bus.din, bus.grant_id, bus.pending_mask); end
      tick();
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b0 || bus.write_reg !== 5'd9 || bus.din !== 32'hBBBB_0009
                    || bus.pending_mask !== 32'd0) begin errors++;
         $display("FAIL idle_hold got en=%b wr=%0d din=%h mask=%h exp 0/9/bbbb0009/0",
                  bus.din_enable, bus.write_reg, bus.din, bus.pending_mask); end
      tick();
   endtask

   task automatic test_single();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++;
         $display("FAIL single_ready got %b%b exp 01", bus.req0_ready, bus.req1_ready); end
      tick();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b1 || bus.write_reg !== 5'd5 || bus.din !== 32'hDEAD_BEEF
                    || bus.grant_id !== 1'b1) begin errors++;
         $display("FAIL single_write got en=%b wr=%0d din=%h gid=%b exp 1/5/deadbeef/1",
                  bus.din_enable, bus.write_reg, bus.din, bus.grant_id); end
      tick();
   endtask

   task automatic test_contention();
      int          exp_seq[8];
      int          i0, i1;
      logic [31:0] prev_data;
      logic [4:0]  prev_rd;
`ifdef GPR_WB_ROUND_ROBIN_EN
      exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      i0 = 0; i1 = 0; prev_data = '0; prev_rd = '0;
      for (int k = 0; k < 9; k++) begin
         drive(i0 < 4, 5'(10 + i0), 32'hA000_0000 + 32'(i0),
               i1 < 4, 5'(20 + i1), 32'hB000_0000 + 32'(i1));
         @(negedge clk);
         if (k < 8) begin
            checks++; if (bus.req0_ready !== (exp_seq[k] == 0) || bus.req1_ready !== (exp_seq[k] == 1))
            begin errors++; $display("FAIL contention_grant k=%0d got %b%b exp id %0d",
                                     k, bus.req0_ready, bus.req1_ready, exp_seq[k]); end
         end
         if (k > 0) begin
            checks++; if (bus.din_enable !== 1'b1 || bus.din !== prev_data || bus.write_reg !== prev_rd
                          || bus.grant_id !== 1'(exp_seq[k-1])) begin errors++;
               $display("FAIL contention_data k=%0d got en=%b wr=%0d din=%h gid=%b exp wr=%0d din=%h",
                        k, bus.din_enable, bus.write_reg, bus.din, bus.grant_id, prev_rd, prev_data);
            end
         end
         tick();
         if (k < 8) begin
            if (exp_seq[k] == 0) begin
               prev_data = 32'hA000_0000 + 32'(i0); prev_rd = 5'(10 + i0); i0++;
            end else begin
               prev_data = 32'hB000_0000 + 32'(i1); prev_rd = 5'(20 + i1); i1++;
            end
         end
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
   endtask

   task automatic test_x0();
      drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checks++; if (bus.req0_ready !== 1'b1 || bus.pending_mask !== 32'd0) begin errors++;
         $display("FAIL x0_accept got rdy=%b mask=%h exp 1/0", bus.req0_ready, bus.pending_mask); end
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b0 || bus.grant_id !== 1'b0 || bus.pending_mask[0] !== 1'b0)
      begin errors++; $display("FAIL x0_drop got en=%b gid=%b mask0=%b exp 0/0/0",
                               bus.din_enable, bus.grant_id, bus.pending_mask[0]); end
      tick();
   endtask

   task automatic test_same_rd();
      // Warm-up LSU write leaves last_grant = 1.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0001);
      tick();
      drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
      @(negedge clk);
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 || bus.pending_mask[7] !== 1'b1)
      begin errors++; $display("FAIL same_rd_first got %b%b m7=%b exp 10/1",
                               bus.req0_ready, bus.req1_ready, bus.pending_mask[7]); end
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b1 || bus.write_reg !== 5'd7 || bus.din !== 32'h11
                    || bus.req1_ready !== 1'b1 || bus.pending_mask[7] !== 1'b1) begin errors++;
         $display("FAIL same_rd_w1 got en=%b wr=%0d din=%h rdy1=%b m7=%b", bus.din_enable,
                  bus.write_reg, bus.din, bus.req1_ready, bus.pending_mask[7]); end
      tick();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b1 || bus.write_reg !== 5'd7 || bus.din !== 32'h22
                    || bus.pending_mask[7] !== 1'b1) begin errors++;
         $display("FAIL same_rd_w2 got en=%b wr=%0d din=%h m7=%b exp 1/7/22/1",
                  bus.din_enable, bus.write_reg, bus.din, bus.pending_mask[7]); end
      tick();
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b0 || bus.pending_mask[7] !== 1'b0) begin errors++;
         $display("FAIL same_rd_done got en=%b m7=%b exp 0/0", bus.din_enable, bus.pending_mask[7]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 5'd4, 32'hCAFE_0004, 1'b0, 5'd0, 32'd0);
      tick();
      reset = 1'b1;
      drive(1'b1, 5'd6, 32'hCAFE_0006, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checks++; if (bus.req0_ready !== 1'b0 || bus.din_enable !== 1'b1) begin errors++;
         $display("FAIL reset_mid_block got rdy0=%b en=%b exp 0/1", bus.req0_ready, bus.din_enable);
      end
      tick();
      reset = 1'b0;
      drive(1'b1, 5'd6, 32'hCAFE_0006, 1'b1, 5'd8, 32'hCAFE_0008);
      @(negedge clk);
      checks++; if (bus.din_enable !== 1'b0 || bus.write_reg !== 5'd0 || bus.din !== 32'd0) begin
         errors++; $display("FAIL reset_mid_cancel got en=%b wr=%0d din=%h exp 0/0/0",
                            bus.din_enable, bus.write_reg, bus.din); end
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++;
         $display("FAIL reset_mid_favour got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
      tick();
      bus.req0_valid = 1'b0;
      tick();
      bus.req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic        v0, v1, w0, w1, lg;
      logic [4:0]  rd0, rd1, exp_rd;
      logic [31:0] d0, d1, exp_data, exp_mask;
      logic        exp_en, exp_gid;
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      reset = 1'b0;
      v0 = 0; v1 = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0;
      lg = 1'b1; exp_en = 1'b0; exp_gid = 1'b0; exp_rd = 0; exp_data = 0;
      for (int c = 0; c < 240; c++) begin
         if (c < 200 && !v0 && $urandom_range(0, 3) != 0) begin
            v0 = 1'b1; rd0 = 5'($urandom_range(0, 31)); d0 = $urandom;
         end
         if (c < 200 && !v1 && $urandom_range(0, 3) != 0) begin
            v1 = 1'b1; rd1 = 5'($urandom_range(0, 31)); d1 = $urandom;
         end
         drive(v0, rd0, d0, v1, rd1, d1);
         w0 = 1'b0; w1 = 1'b0;
         if (v0 && v1) begin
`ifdef GPR_WB_ROUND_ROBIN_EN
            w0 = (lg == 1'b1); w1 = (lg == 1'b0);
`else
            w0 = 1'b1;
`endif
         end else begin
            w0 = v0; w1 = v1;
         end
         exp_mask = 32'd0;
         if (v0) exp_mask = exp_mask | (32'd1 << rd0);
         if (v1) exp_mask = exp_mask | (32'd1 << rd1);
         if (exp_en) exp_mask = exp_mask | (32'd1 << exp_rd);
         exp_mask = exp_mask & ~32'd1;
         @(negedge clk);
         checks++; if (bus.req0_ready !== w0 || bus.req1_ready !== w1) begin errors++;
            $display("FAIL rand_ready c=%0d got %b%b exp %b%b", c, bus.req0_ready, bus.req1_ready,
                     w0, w1); end
         checks++; if (bus.din_enable !== exp_en || bus.grant_id !== exp_gid
                       || (exp_en && (bus.write_reg !== exp_rd || bus.din !== exp_data))) begin
            errors++; $display("FAIL rand_out c=%0d got en=%b gid=%b wr=%0d din=%h exp %b/%b/%0d/%h",
                               c, bus.din_enable, bus.grant_id, bus.write_reg, bus.din,
                               exp_en, exp_gid, exp_rd, exp_data); end
         checks++; if (bus.pending_mask !== exp_mask) begin errors++;
            $display("FAIL rand_mask c=%0d got %h exp %h", c, bus.pending_mask, exp_mask); end
         tick();
         if (w0) begin
            exp_en = (rd0 != 5'd0); exp_rd = rd0; exp_data = d0; exp_gid = 1'b0; lg = 1'b0; v0 = 1'b0;
         end else if (w1) begin
            exp_en = (rd1 != 5'd0); exp_rd = rd1; exp_data = d1; exp_gid = 1'b1; lg = 1'b1; v1 = 1'b0;
         end else begin
            exp_en = 1'b0;
         end
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      test_reset();
      test_single();
      test_contention();
      test_x0();
      test_same_rd();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
